mem_io_hub: RTL and testbench

- Sits directly downstream of the cpu top, on its byte-wide memory bus (mem_a / mem_dout / mem_wr / mem_din).
- Decodes each bus access as either a RAM access or an I/O access. I/O space is selected by a[17:16]==2'b11.
- Forwards RAM traffic to the 128 KB block RAM and returns read data with a fixed one-cycle latency.
- Implements the UART-mapped I/O registers, the cycle counter, the TX buffer that drives io_buffer_full, and the program-stop flag.

---
 rtl/mem_io_hub_pkg.sv | 9 +
 rtl/mem_io_hub_fifo.sv | 50 +++++
 rtl/mem_io_hub.sv | 136 +++++++++++++
 tb/tb_mem_io_hub.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_hub_pkg.sv
// Shared address-map constants for the memory/I-O hub.
package mem_io_hub_pkg;

  localparam logic [1:0] IO_BASE = 2'b11;
  localparam logic [2:0] IO_UART = 3'h0;
  localparam logic [2:0] IO_CLK  = 3'h4;
  localparam int         RAM_AW  = 17;

endpackage

// File: rtl/mem_io_hub_fifo.sv
// Parameterised synchronous circular FIFO; push while full is accepted only with a same-cycle pop.
module hub_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;
  logic          w_push;

  assign empty      = (r_count == '0);
  assign full       = (r_count == (AW+1)'(DEPTH));
  assign w_pop      = pop & ~empty;
  assign w_push     = push & (~full | w_pop);
  assign count      = r_count;
  assign count_next = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign dout       = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= count_next;
    end
  end

endmodule

// File: rtl/mem_io_hub.sv
// Byte-bus hub: splits cpu accesses between block RAM and the UART/clock I/O registers.
module mem_io_hub
  import mem_io_hub_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int TX_AW       = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic              clk_in,
  input  logic              rst_in_n,
  input  logic              rdy_in,
  input  logic [31:0]       cpu_a,
  input  logic [7:0]        cpu_dout,
  input  logic              cpu_wr,
  output logic [7:0]        cpu_din,
  output logic              io_buffer_full,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              prog_stop,
  output logic              tx_overflow
);

  logic         w_is_io;
  logic [2:0]   w_io_sel;
  logic         w_io_rd;
  logic         w_io_wr;
  logic         w_tx_push;
  logic [7:0]   w_tx_din;
  logic [7:0]   w_io_rdata;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic [TX_AW:0] w_count;
  logic [TX_AW:0] w_count_next;
  logic         w_unused_a;

  logic         r_sel_io;
  logic         r_sel_ram;
  logic [7:0]   r_io_rdata;
  logic [31:0]  r_cycle_cnt;
  logic [31:0]  r_snap;
  logic         r_prog_stop;
  logic         r_overflow;
  logic         r_buf_full;

  assign w_unused_a = ^{cpu_a[31:18], cpu_a[15:3], w_count};

  assign w_is_io  = (cpu_a[17:16] == IO_BASE);
  assign w_io_sel = cpu_a[2:0];
  assign w_io_rd  = rdy_in & w_is_io & ~cpu_wr;
  assign w_io_wr  = rdy_in & w_is_io & cpu_wr;

  assign ram_en   = rdy_in & ~w_is_io;
  assign ram_wr   = ram_en & cpu_wr;
  assign ram_a    = cpu_a[RAM_AW-1:0];
  assign ram_dout = cpu_dout;

  assign rx_ready = w_io_rd & (w_io_sel == IO_UART) & rx_valid;

  // A clock-register write queues a 0x00 so the host sees the stop in-band.
  assign w_tx_push = w_io_wr & (((w_io_sel == IO_UART) & (cpu_dout != 8'h00)) |
                                (w_io_sel == IO_CLK));
  assign w_tx_din  = (w_io_sel == IO_CLK) ? 8'h00 : cpu_dout;

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_io_sel)
      IO_UART: w_io_rdata = rx_valid ? rx_data : 8'h00;
      3'h4:    w_io_rdata = r_cycle_cnt[7:0];
      3'h5:    w_io_rdata = r_snap[15:8];
      3'h6:    w_io_rdata = r_snap[23:16];
      3'h7:    w_io_rdata = r_snap[31:24];
      default: w_io_rdata = 8'h00;
    endcase
  end

  // RAM data is forwarded combinationally; the RAM-select flag keeps cpu_din at 0 until a RAM access.
  assign cpu_din = r_sel_io ? r_io_rdata : (r_sel_ram ? ram_din : 8'h00);

  hub_fifo #(
    .DEPTH (TX_DEPTH),
    .AW    (TX_AW),
    .DW    (8)
  ) u_tx_fifo (
    .clk        (clk_in),
    .rst_n      (rst_in_n),
    .push       (w_tx_push),
    .din        (w_tx_din),
    .pop        (tx_ready),
    .dout       (tx_data),
    .count      (w_count),
    .count_next (w_count_next),
    .full       (w_fifo_full),
    .empty      (w_fifo_empty)
  );

  assign tx_valid       = ~w_fifo_empty;
  assign prog_stop      = r_prog_stop;
  assign tx_overflow    = r_overflow;
  assign io_buffer_full = r_buf_full;

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      r_sel_io    <= 1'b0;
      r_sel_ram   <= 1'b0;
      r_io_rdata  <= '0;
      r_cycle_cnt <= '0;
      r_snap      <= '0;
      r_prog_stop <= 1'b0;
      r_overflow  <= 1'b0;
      r_buf_full  <= 1'b0;
    end else begin
      if (rdy_in) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
        r_sel_io    <= w_is_io;
        r_sel_ram   <= ~w_is_io;
      end
      if (w_io_rd) begin
        r_io_rdata <= w_io_rdata;
        if (w_io_sel == IO_CLK) r_snap <= r_cycle_cnt;
      end
      if (w_io_wr && (w_io_sel == IO_CLK)) r_prog_stop <= 1'b1;
      if (w_tx_push && w_fifo_full && !tx_ready) r_overflow <= 1'b1;
      r_buf_full <= (w_count_next >= (TX_AW+1)'(TX_DEPTH - FULL_MARGIN));
    end
  end

endmodule

// File: tb/tb_mem_io_hub.sv
// Directed self-checking bench for mem_io_hub with a behavioural block-RAM model.
module tb_mem_io_hub;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        rdy_in;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        io_buffer_full;
  logic        ram_en;
  logic        ram_wr;
  logic [16:0] ram_a;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        prog_stop;
  logic        tx_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_pops  = 0;
  logic [7:0] tx_last = 8'h00;
  logic [7:0] ram_mem [131072];

  always #5 clk_in = ~clk_in;

  mem_io_hub #(
    .TX_DEPTH    (16),
    .TX_AW       (4),
    .FULL_MARGIN (2)
  ) dut (
    .clk_in         (clk_in),
    .rst_in_n       (rst_in_n),
    .rdy_in         (rdy_in),
    .cpu_a          (cpu_a),
    .cpu_dout       (cpu_dout),
    .cpu_wr         (cpu_wr),
    .cpu_din        (cpu_din),
    .io_buffer_full (io_buffer_full),
    .ram_en         (ram_en),
    .ram_wr         (ram_wr),
    .ram_a          (ram_a),
    .ram_dout       (ram_dout),
    .ram_din        (ram_din),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .prog_stop      (prog_stop),
    .tx_overflow    (tx_overflow)
  );

  always @(posedge clk_in) begin
    if (ram_en) begin
      if (ram_wr) ram_mem[ram_a] <= ram_dout;
      ram_din <= ram_mem[ram_a];
    end
  end

  always @(posedge clk_in) begin
    if (rst_in_n && tx_valid && tx_ready) begin
      tx_pops <= tx_pops + 1;
      tx_last <= tx_data;
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
    cpu_wr   = wr;
    cpu_a    = a;
    cpu_dout = d;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 8'h00);
    rdy_in   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    rst_in_n = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_in_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 8'h00);
    rdy_in = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    ram_din = 8'h6C;
    rst_in_n = 1'b0;
    #3;
    n_checks++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL reset_cpu_din got %h want 00", cpu_din); end
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL reset_buf_full got %b want 0", io_buffer_full); end
    n_checks++; if (prog_stop !== 1'b0 || tx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_sticky got %b%b want 00", prog_stop, tx_overflow); end
    repeat (2) @(posedge clk_in);
    #1 rst_in_n = 1'b1;
  endtask

  task automatic test_ram();
    do_reset();
    rdy_in = 1'b1;
    drive(1'b1, 32'h0000_0123, 8'hA5);
    #1;
    n_checks++; if (ram_en !== 1'b1 || ram_wr !== 1'b1) begin n_fail++; $display("FAIL ram_wr_strobe got en=%b wr=%b want 1 1", ram_en, ram_wr); end
    n_checks++; if (ram_a !== 17'h00123 || ram_dout !== 8'hA5) begin n_fail++; $display("FAIL ram_wr_addr got a=%h d=%h want 00123 a5", ram_a, ram_dout); end
    step();
    drive(1'b0, 32'h0000_0123, 8'h00);
    #1;
    n_checks++; if (ram_en !== 1'b1 || ram_wr !== 1'b0) begin n_fail++; $display("FAIL ram_rd_strobe got en=%b wr=%b want 1 0", ram_en, ram_wr); end
    step();
    n_checks++; if (cpu_din !== 8'hA5) begin n_fail++; $display("FAIL ram_rd_data got %h want a5", cpu_din); end
    drive(1'b0, 32'h0003_0000, 8'h00);
    #1;
    n_checks++; if (ram_en !== 1'b0) begin n_fail++; $display("FAIL ram_en_on_io got %b want 0", ram_en); end
  endtask

  task automatic test_uart_out();
    int pops0;
    do_reset();
    rdy_in = 1'b1; tx_ready = 1'b1;
    pops0 = tx_pops;
    drive(1'b1, 32'h0003_0000, 8'h41);
    step();
    n_checks++; if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin n_fail++; $display("FAIL uart_push got v=%b d=%h want 1 41", tx_valid, tx_data); end
    drive(1'b1, 32'h0003_0000, 8'h00);
    step();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL uart_zero_ignored got tx_valid=%b want 0", tx_valid); end
    drive(1'b0, 32'h0, 8'h00);
    repeat (3) step();
    n_checks++; if (tx_pops - pops0 != 1 || tx_last !== 8'h41) begin n_fail++; $display("FAIL uart_pop_count got n=%0d last=%h want 1 41", tx_pops - pops0, tx_last); end
  endtask

  task automatic test_clock_coherence();
    logic [7:0] exp_b [8];
    logic [31:0] addr [8];
    exp_b = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00};
    addr  = '{32'h30004, 32'h30005, 32'h30006, 32'h30007,
              32'h30004, 32'h30005, 32'h30006, 32'h30007};
    do_reset();
    rdy_in = 1'b1;
    repeat (255) @(posedge clk_in);
    #1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, addr[i], 8'h00);
      step();
      n_checks++;
      if (cpu_din !== exp_b[i]) begin
        n_fail++; $display("FAIL clk_read_%0d addr=%h got %h want %h", i, addr[i], cpu_din, exp_b[i]);
      end
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    rdy_in = 1'b1; tx_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      drive(1'b1, 32'h0003_0000, 8'(i));
      step();
      if (i == 13) begin
        n_checks++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL bp_full_13 got %b want 0", io_buffer_full); end
      end
      if (i == 14) begin
        n_checks++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL bp_full_14 got %b want 1", io_buffer_full); end
      end
      if (i == 16) begin
        n_checks++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL bp_ovf_16 got %b want 0", tx_overflow); end
      end
      if (i == 17) begin
        n_checks++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_ovf_17 got %b want 1", tx_overflow); end
      end
    end
    n_checks++; if (tx_data !== 8'h01) begin n_fail++; $display("FAIL bp_head got %h want 01", tx_data); end
    drive(1'b0, 32'h0, 8'h00);
    tx_ready = 1'b1;
    step();
    n_checks++; if (io_buffer_full !== 1'b1 || tx_data !== 8'h02) begin n_fail++; $display("FAIL bp_drain15 got full=%b d=%h want 1 02", io_buffer_full, tx_data); end
    step();
    step();
    n_checks++; if (io_buffer_full !== 1'b0 || tx_data !== 8'h04) begin n_fail++; $display("FAIL bp_drain13 got full=%b d=%h want 0 04", io_buffer_full, tx_data); end
    repeat (13) step();
    n_checks++; if (tx_valid !== 1'b0 || tx_last !== 8'h10) begin n_fail++; $display("FAIL bp_drained got v=%b last=%h want 0 10", tx_valid, tx_last); end
  endtask

  task automatic test_stop_rx();
    do_reset();
    rdy_in = 1'b1; tx_ready = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h37;
    drive(1'b0, 32'h0003_0000, 8'h00);
    #1;
    n_checks++; if (rx_ready !== 1'b1) begin n_fail++; $display("FAIL rx_ready_pulse got %b want 1", rx_ready); end
    step();
    n_checks++; if (cpu_din !== 8'h37) begin n_fail++; $display("FAIL rx_data got %h want 37", cpu_din); end
    drive(1'b0, 32'h0003_0002, 8'h00);
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_single got %b want 0", rx_ready); end
    step();
    n_checks++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL io_unmapped got %h want 00", cpu_din); end
    rx_valid = 1'b0;
    drive(1'b0, 32'h0003_0000, 8'h00);
    #1;
    n_checks++; if (rx_ready !== 1'b0) begin n_fail++; $display("FAIL rx_ready_empty got %b want 0", rx_ready); end
    step();
    n_checks++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL rx_empty_data got %h want 00", cpu_din); end
    drive(1'b1, 32'h0003_0004, 8'h55);
    step();
    n_checks++; if (prog_stop !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin n_fail++; $display("FAIL stop_write got stop=%b v=%b d=%h want 1 1 00", prog_stop, tx_valid, tx_data); end
    drive(1'b0, 32'h0, 8'h00);
    repeat (3) step();
    n_checks++; if (prog_stop !== 1'b1) begin n_fail++; $display("FAIL stop_sticky got %b want 1", prog_stop); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    rdy_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    rdy_in = 1'b0;
    drive(1'b1, 32'h0003_0000, 8'h5A);
    repeat (10) step();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_push got %b want 0", tx_valid); end
    rdy_in = 1'b1;
    drive(1'b0, 32'h0003_0004, 8'h00);
    step();
    n_checks++; if (cpu_din !== 8'h05) begin n_fail++; $display("FAIL stall_cnt_frozen got %h want 05", cpu_din); end
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'h0003_0000, 8'(8'h11 + i));
      step();
    end
    drive(1'b1, 32'h0003_0004, 8'h01);
    step();
    drive(1'b0, 32'h0003_0005, 8'h00);
    tx_ready = 1'b1;
    step();
    n_checks++; if (tx_valid !== 1'b1 || prog_stop !== 1'b1) begin n_fail++; $display("FAIL pre_reset got v=%b stop=%b want 1 1", tx_valid, prog_stop); end
    #2 rst_in_n = 1'b0;
    #1;
    n_checks++; if (tx_valid !== 1'b0 || prog_stop !== 1'b0 || io_buffer_full !== 1'b0 || tx_overflow !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got v=%b stop=%b full=%b ovf=%b want 0 0 0 0", tx_valid, prog_stop, io_buffer_full, tx_overflow);
    end
    n_checks++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL async_reset_din got %h want 00", cpu_din); end
    step();
    rst_in_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_uart_out();
    test_clock_coherence();
    test_back_pressure();
    test_stop_rx();
    test_stall_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
